// File: rtl/opm_write_sched.sv
// Queues host (reg,dat) writes and replays them to the OPM core as an
// address write followed by a data write, with setup/strobe/gap timing.
module opm_write_sched #(
   parameter int FIFO_AW    = 4,
   parameter int SETUP_CYC  = 4,
   parameter int STROBE_CYC = 8,
   parameter int GAP_CYC    = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [7:0]       reg_i,
   input  logic [7:0]       dat_i,
   input  logic             flush_i,
   input  logic             clr_ovf_i,
   output logic             full_o,
   output logic [FIFO_AW:0] level_o,
   output logic             overflow_o,
   output logic             busy_o,
   input  logic             opm_busy_i,
   output logic             opm_cs_n_o,
   output logic             opm_wr_n_o,
   output logic             opm_a0_o,
   output logic [7:0]       opm_d_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int MAXC0 = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAXC  = (MAXC0 > GAP_CYC) ? MAXC0 : GAP_CYC;
   localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0]      LD_SET   = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0]      LD_STB   = CW'(STROBE_CYC - 1);
   // A zero gap still spends one HOLD cycle so opm_busy_i gets sampled.
   localparam logic [CW-1:0]      LD_GAP   = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_ASET, S_ASTB, S_AREL, S_DSET, S_DSTB, S_DREL, S_HOLD
   } state_t;

   logic [15:0]        r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_level;
   logic               r_ovf;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [15:0]        r_ent;
   logic               r_cs_n;
   logic               r_wr_n;
   logic               r_a0;
   logic [7:0]         r_d;

   logic               w_full;
   logic               w_push;
   logic               w_drop;
   logic               w_pop;
   logic               w_done;
   state_t             w_nstate;
   logic [CW-1:0]      w_ncnt;
   logic [15:0]        w_ent;
   logic               w_cs_n;
   logic               w_wr_n;
   logic               w_a0;
   logic [7:0]         w_d;

   // full is taken from the registered level, so a pop this cycle never
   // makes room for a push in the same cycle.
   assign w_full = (r_level == LVL_FULL);
   assign w_push = wr_i && !w_full && !flush_i;
   assign w_drop = wr_i && w_full && !flush_i;
   assign w_done = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {reg_i, dat_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_ovf <= 1'b0;
      else if (w_drop)    r_ovf <= 1'b1;
      else if (clr_ovf_i) r_ovf <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ent   <= '0;
         r_cs_n  <= 1'b1;
         r_wr_n  <= 1'b1;
         r_a0    <= 1'b0;
         r_d     <= '0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_ent   <= w_ent;
         r_cs_n  <= w_cs_n;
         r_wr_n  <= w_wr_n;
         r_a0    <= w_a0;
         r_d     <= w_d;
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_pop    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_level != '0 && !flush_i) begin
               w_pop    = 1'b1;
               w_nstate = S_ASET;
            end
         end
         S_ASET:  if (w_done) w_nstate = S_ASTB;
         S_ASTB:  if (w_done) w_nstate = S_AREL;
         S_AREL:  if (w_done) w_nstate = S_DSET;
         S_DSET:  if (w_done) w_nstate = S_DSTB;
         S_DSTB:  if (w_done) w_nstate = S_DREL;
         S_DREL:  if (w_done) w_nstate = S_HOLD;
         S_HOLD:  if (w_done && !opm_busy_i) w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
   end

   // One shared down-counter, reloaded whenever the state changes.
   always_comb begin
      w_ncnt = r_cnt;
      if (w_nstate != r_state) begin
         case (w_nstate)
            S_ASTB, S_DSTB: w_ncnt = LD_STB;
            S_HOLD:         w_ncnt = LD_GAP;
            S_IDLE:         w_ncnt = '0;
            default:        w_ncnt = LD_SET;
         endcase
      end else if (!w_done) begin
         w_ncnt = r_cnt - CNT_ONE;
      end
   end

   // Bus outputs are decoded from the next state so they register together
   // with the state they belong to.
   assign w_ent = w_pop ? r_mem[r_rptr] : r_ent;

   always_comb begin
      w_cs_n = 1'b1;
      w_wr_n = 1'b1;
      w_a0   = r_a0;
      w_d    = r_d;
      case (w_nstate)
         S_ASET, S_AREL: begin
            w_cs_n = (w_nstate == S_AREL);
            w_a0   = 1'b0;
            w_d    = w_ent[15:8];
         end
         S_ASTB: begin
            w_cs_n = 1'b0;
            w_wr_n = 1'b0;
            w_a0   = 1'b0;
            w_d    = w_ent[15:8];
         end
         S_DSET, S_DREL, S_HOLD: begin
            w_cs_n = (w_nstate != S_DSET);
            w_a0   = 1'b1;
            w_d    = w_ent[7:0];
         end
         S_DSTB: begin
            w_cs_n = 1'b0;
            w_wr_n = 1'b0;
            w_a0   = 1'b1;
            w_d    = w_ent[7:0];
         end
         default: ;
      endcase
   end

   assign full_o     = w_full;
   assign level_o    = r_level;
   assign overflow_o = r_ovf;
   assign busy_o     = (r_level != '0) || (r_state != S_IDLE);
   assign opm_cs_n_o = r_cs_n;
   assign opm_wr_n_o = r_wr_n;
   assign opm_a0_o   = r_a0;
   assign opm_d_o    = r_d;

endmodule

// File: tb/tb_opm_write_sched.sv
// Bench for opm_write_sched: flag vector table, hand-built timing sequences
// and a randomized run against a transaction-offset reference model.
module tb_opm_write_sched;

   localparam int S     = 4;
   localparam int T     = 8;
   localparam int G     = 64;
   localparam int L     = 4*S + 2*T + G;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_i = 1'b0, flush_i = 1'b0, clr_ovf_i = 1'b0, opm_busy_i = 1'b0;
   logic [7:0] reg_i = '0, dat_i = '0;
   logic       full_o, overflow_o, busy_o, opm_cs_n_o, opm_wr_n_o, opm_a0_o;
   logic [4:0] level_o;
   logic [7:0] opm_d_o;

   opm_write_sched #(.FIFO_AW(4), .SETUP_CYC(S), .STROBE_CYC(T), .GAP_CYC(G)) dut (
      .clk(clk), .rst(rst), .wr_i(wr_i), .reg_i(reg_i), .dat_i(dat_i),
      .flush_i(flush_i), .clr_ovf_i(clr_ovf_i), .full_o(full_o), .level_o(level_o),
      .overflow_o(overflow_o), .busy_o(busy_o), .opm_busy_i(opm_busy_i),
      .opm_cs_n_o(opm_cs_n_o), .opm_wr_n_o(opm_wr_n_o), .opm_a0_o(opm_a0_o),
      .opm_d_o(opm_d_o));

   always #20 clk = ~clk;

   int n_tests = 0, n_fail = 0, cyc = 0, wr_low = 0;
   int acs_q[$];
   logic [8:0] wr_q[$];
   logic p_cs = 1'b1, p_wr = 1'b1;

   // Reference model: queue of pairs plus offset into the current transaction.
   logic [15:0] m_q[$];
   bit          m_act, m_ovf;
   int          m_pos;
   logic [15:0] m_cur;
   logic        m_cs, m_wr, m_a0;
   logic [7:0]  m_d;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_q.delete(); m_act = 0; m_ovf = 0; m_pos = 0; m_cur = '0;
      m_cs = 1; m_wr = 1; m_a0 = 0; m_d = '0;
   endtask

   task automatic model_update();
      bit was_full, drop;
      int seg;
      if (rst) begin model_reset(); return; end
      was_full = (m_q.size() == DEPTH);
      drop     = wr_i && was_full && !flush_i;
      if (m_act) begin
         if (m_pos >= L-1) begin
            if (!opm_busy_i) m_act = 0;
         end else m_pos++;
      end else if (m_q.size() != 0 && !flush_i) begin
         m_cur = m_q.pop_front(); m_act = 1; m_pos = 0;
      end
      if (flush_i) m_q.delete();
      else if (wr_i && !was_full) m_q.push_back({reg_i, dat_i});
      if (drop) m_ovf = 1;
      else if (clr_ovf_i) m_ovf = 0;
      m_cs = 1; m_wr = 1;
      if (m_act) begin
         seg = (m_pos < S) ? 0 : (m_pos < S+T) ? 1 : (m_pos < 2*S+T) ? 2 :
               (m_pos < 3*S+T) ? 3 : (m_pos < 3*S+2*T) ? 4 : 5;
         m_a0 = (seg >= 3);
         m_d  = m_a0 ? m_cur[7:0] : m_cur[15:8];
         m_cs = (seg == 2 || seg == 5);
         m_wr = !(seg == 1 || seg == 4);
      end
   endtask

   task automatic step();
      logic [4:0] lv;
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc++;
      lv = 5'(m_q.size());
      chk("model", 32'({opm_cs_n_o, opm_wr_n_o, opm_a0_o, opm_d_o, level_o, full_o, overflow_o, busy_o}),
          32'({m_cs, m_wr, m_a0, m_d, lv, (m_q.size() == DEPTH), m_ovf, (m_q.size() != 0 || m_act)}));
      if (p_cs && !opm_cs_n_o && !opm_a0_o) acs_q.push_back(cyc);
      if (p_wr && !opm_wr_n_o) wr_q.push_back({opm_a0_o, opm_d_o});
      if (!opm_wr_n_o) wr_low++;
      p_cs = opm_cs_n_o;
      p_wr = opm_wr_n_o;
   endtask

   task automatic do_reset();
      wr_i = 0; flush_i = 0; clr_ovf_i = 0; opm_busy_i = 0; rst = 1;
      step(); step();
      rst = 0;
      acs_q.delete(); wr_q.delete(); wr_low = 0;
   endtask

   task automatic push(input logic [7:0] r, input logic [7:0] d);
      wr_i = 1; reg_i = r; dat_i = d;
      step();
      wr_i = 0;
   endtask

   task automatic run_idle(input int bound);
      int n = 0;
      while (busy_o && n < bound) begin step(); n++; end
      chk("idle_timeout", 32'(n < bound), 32'd1);
   endtask

   typedef struct {
      logic wr, flush, clr;
      logic [7:0] r, d;
      logic [4:0] lvl;
      logic full, ovf;
   } vec_t;

   function automatic vec_t mk(logic wr, logic fl, logic cl, logic [7:0] r, logic [7:0] d,
                               logic [4:0] lvl, logic full, logic ovf);
      vec_t v;
      v.wr = wr; v.flush = fl; v.clr = cl; v.r = r; v.d = d;
      v.lvl = lvl; v.full = full; v.ovf = ovf;
      return v;
   endfunction

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[24];
      int base, k, n, nw;

      // Table: the first entry goes in flight, then 16 fill the FIFO.
      tbl[0] = mk(1, 0, 0, 8'hA0, 8'h01, 5'd1, 0, 0);
      tbl[1] = mk(0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0);
      for (int i = 2; i <= 17; i++)
         tbl[i] = mk(1, 0, 0, 8'(i), 8'(i*3), 5'(i-1), (i == 17), 0);
      tbl[18] = mk(1, 0, 0, 8'hEE, 8'hEE, 5'd16, 1, 1);
      tbl[19] = mk(0, 0, 1, 8'h00, 8'h00, 5'd16, 1, 0);
      tbl[20] = mk(1, 0, 1, 8'hEF, 8'hEF, 5'd16, 1, 1);
      tbl[21] = mk(0, 0, 1, 8'h00, 8'h00, 5'd16, 1, 0);
      tbl[22] = mk(1, 1, 0, 8'hF0, 8'hF0, 5'd0, 0, 0);
      tbl[23] = mk(1, 0, 0, 8'hF1, 8'hF1, 5'd1, 0, 0);

      model_reset();
      step(); step();
      chk("rst_cs_n", 32'(opm_cs_n_o), 32'd1);
      chk("rst_wr_n", 32'(opm_wr_n_o), 32'd1);
      chk("rst_a0",   32'(opm_a0_o),   32'd0);
      chk("rst_d",    32'(opm_d_o),    32'd0);
      chk("rst_lvl",  32'(level_o),    32'd0);
      chk("rst_full", 32'(full_o),     32'd0);
      chk("rst_ovf",  32'(overflow_o), 32'd0);
      chk("rst_busy", 32'(busy_o),     32'd0);
      rst = 0;

      // Flag table
      do_reset();
      for (int i = 0; i < 24; i++) begin
         wr_i = tbl[i].wr; flush_i = tbl[i].flush; clr_ovf_i = tbl[i].clr;
         reg_i = tbl[i].r; dat_i = tbl[i].d;
         step();
         chk("vec_lvl",  32'(level_o),    32'(tbl[i].lvl));
         chk("vec_full", 32'(full_o),     32'(tbl[i].full));
         chk("vec_ovf",  32'(overflow_o), 32'(tbl[i].ovf));
      end
      wr_i = 0; flush_i = 0; clr_ovf_i = 0;

      // Single pair: latency, phases, strobe widths, busy length
      do_reset();
      base = cyc;
      push(8'h28, 8'h42);
      chk("single_lvl1", 32'(level_o), 32'd1);
      chk("single_cs_c1", 32'(opm_cs_n_o), 32'd1);
      step();
      chk("single_cs_c2", 32'(opm_cs_n_o), 32'd0);
      chk("single_d_c2", 32'({opm_a0_o, opm_d_o}), 32'h028);
      run_idle(200);
      chk("single_busy_len", 32'(cyc - base - 1), 32'd97);
      chk("single_pulses", 32'(wr_q.size()), 32'd2);
      chk("single_wr_low", 32'(wr_low), 32'(2*T));
      if (wr_q.size() == 2) begin
         chk("single_aphase", 32'(wr_q[0]), 32'h028);
         chk("single_dphase", 32'(wr_q[1]), 32'h142);
      end

      // Three pairs back to back
      do_reset();
      base = cyc;
      push(8'h40, 8'h02); push(8'h50, 8'h01); push(8'h60, 8'h15);
      run_idle(400);
      chk("three_nfall", 32'(acs_q.size()), 32'd3);
      chk("three_nwr", 32'(wr_q.size()), 32'd6);
      if (acs_q.size() == 3) begin
         chk("three_first", 32'(acs_q[0] - base), 32'd2);
         chk("three_gap1", 32'(acs_q[1] - acs_q[0]), 32'd97);
         chk("three_gap2", 32'(acs_q[2] - acs_q[1]), 32'd97);
      end
      if (wr_q.size() == 6) begin
         chk("three_o0", 32'(wr_q[0]), 32'h040); chk("three_o1", 32'(wr_q[1]), 32'h102);
         chk("three_o2", 32'(wr_q[2]), 32'h050); chk("three_o3", 32'(wr_q[3]), 32'h101);
         chk("three_o4", 32'(wr_q[4]), 32'h060); chk("three_o5", 32'(wr_q[5]), 32'h115);
      end

      // OPM busy held from DREL onward
      do_reset();
      push(8'h11, 8'h22); push(8'h33, 8'h44);
      n = 0;
      while (!(wr_q.size() == 2 && opm_wr_n_o) && n < 100) begin step(); n++; end
      chk("obusy_reach_drel", 32'(n < 100), 32'd1);
      opm_busy_i = 1;
      nw = wr_q.size();
      repeat (200) step();
      chk("obusy_no_pulse", 32'(wr_q.size()), 32'(nw));
      chk("obusy_no_aset", 32'(acs_q.size()), 32'd1);
      opm_busy_i = 0;
      k = cyc;
      n = 0;
      while (acs_q.size() < 2 && n < 10) begin step(); n++; end
      chk("obusy_resume_to", 32'(acs_q.size()), 32'd2);
      if (acs_q.size() == 2) chk("obusy_resume", 32'(acs_q[1] - k), 32'd2);
      run_idle(200);

      // Asynchronous reset during data strobe
      do_reset();
      push(8'h21, 8'h99); push(8'h22, 8'h98);
      n = 0;
      while (!(!opm_wr_n_o && opm_a0_o) && n < 100) begin step(); n++; end
      chk("arst_reach_dstb", 32'(n < 100), 32'd1);
      #5 rst = 1;
      #1;
      chk("arst_wr_n", 32'(opm_wr_n_o), 32'd1);
      chk("arst_cs_n", 32'(opm_cs_n_o), 32'd1);
      chk("arst_lvl",  32'(level_o),    32'd0);
      chk("arst_a0",   32'(opm_a0_o),   32'd0);
      step();
      rst = 0;
      wr_q.delete();
      push(8'h30, 8'h07);
      run_idle(200);
      chk("arst_after_n", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         chk("arst_after_a", 32'(wr_q[0]), 32'h030);
         chk("arst_after_d", 32'(wr_q[1]), 32'h107);
      end

      // Flush with five queued while the first pair is in its address strobe
      do_reset();
      for (int i = 0; i < 6; i++) push(8'(8'h70 + i), 8'(i));
      n = 0;
      while (!(!opm_wr_n_o && !opm_a0_o) && n < 50) begin step(); n++; end
      chk("flush_reach_astb", 32'(n < 50), 32'd1);
      chk("flush_lvl_pre", 32'(level_o), 32'd5);
      flush_i = 1;
      step();
      flush_i = 0;
      chk("flush_lvl", 32'(level_o), 32'd0);
      run_idle(200);
      repeat (120) step();
      chk("flush_pulses", 32'(wr_q.size()), 32'd2);
      chk("flush_txns", 32'(acs_q.size()), 32'd1);
      if (wr_q.size() == 2) chk("flush_dphase", 32'(wr_q[1]), 32'h100);

      // Randomized traffic against the model
      do_reset();
      begin
         int burst = 0;
         for (int i = 0; i < 4000; i++) begin
            if (burst == 0 && $urandom_range(0, 299) == 0) burst = 20;
            wr_i = (burst > 0) || ($urandom_range(0, 15) == 0);
            if (burst > 0) burst--;
            reg_i = 8'($urandom); dat_i = 8'($urandom);
            flush_i = ($urandom_range(0, 499) == 0);
            clr_ovf_i = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) opm_busy_i = ~opm_busy_i;
            step();
         end
      end
      wr_i = 0; flush_i = 0; clr_ovf_i = 0; opm_busy_i = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
